lmem_decode_sched: RTL

Sequencing controller for the SRQ-type bit-node (LLR) memory of the QC-LDPC layered decoder (Z=511, P=26, Nb=16, 2 layers). It runs one codeword through four phases:

- loads the codeword (17 beats of 32 rows);
- issues per-layer read/write strobes to the memory and RCU pipeline for up to MAXITRS iterations;
- unloads hard decisions;
- reports completion.

It sits between the top-level decoder control and the Lmem/RCU datapath, driving every Lmem control pin.

---
 rtl/lmem_decode_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lmem_decode_sched.sv
// Sequencer for the layered QC-LDPC bit-node (Lmem) memory: load, per-layer read/write, unload, done.
// Optional build macro LMEM_EARLY_TERM_EN: when defined, parity_ok ends decoding early at an iteration boundary.
module lmem_decode_sched #(
  parameter int MAXITRS     = 10,
  parameter int ITRWIDTH    = 4,
  parameter int LAYERS      = 2,
  parameter int ROWDEPTH    = 20,
  parameter int ROWWIDTH    = 5,
  parameter int PIPESTAGES  = 15,
  parameter int LOADBEATS   = 17,
  parameter int UNLOADBEATS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                load_valid,
  input  logic                parity_ok,
  output logic                busy,
  output logic                load_ready,
  output logic                loaden,
  output logic                rd_en,
  output logic [ROWWIDTH-1:0] rd_address,
  output logic                rd_layer,
  output logic                wr_en,
  output logic                wr_layer,
  output logic                firstprocessing_indicate,
  output logic                unload_en,
  output logic [ROWWIDTH-1:0] unloadAddress,
  output logic                hd_valid,
  output logic [ITRWIDTH-1:0] itr_count,
  output logic                done
);

  localparam int BEATW = (LOADBEATS > 1) ? $clog2(LOADBEATS) : 1;
  localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_DRAIN,
    S_UNLOAD,
    S_FIN
  } state_t;

  state_t              state, state_nxt;
  logic [BEATW-1:0]    beat_q, beat_nxt;
  logic [LW-1:0]       layer_q, layer_nxt;
  logic [ITRWIDTH-1:0] itr_q, itr_nxt, itr_inc;
  logic [ROWWIDTH-1:0] rd_addr_q, rd_addr_nxt;
  logic [ROWWIDTH-1:0] ul_addr_q, ul_addr_nxt;

  logic [PIPESTAGES-1:0] vld_pipe;
  logic [PIPESTAGES-1:0] layer_pipe;
  logic [PIPESTAGES-1:0] first_pipe;
  logic                  hd_vld_p0;
  logic                  itr_zero;
  logic                  layer_last;
  logic                  last_wr;

`ifndef LMEM_EARLY_TERM_EN
  logic parity_unused;
  assign parity_unused = parity_ok;
`endif

  function automatic logic [ITRWIDTH-1:0] sat_inc(input logic [ITRWIDTH-1:0] v);
    return (v >= ITRWIDTH'(MAXITRS)) ? v : v + 1'b1;
  endfunction

  assign itr_inc    = sat_inc(itr_q);
  assign itr_zero   = (itr_q == '0);
  assign layer_last = (layer_q == LW'(LAYERS - 1));

  assign busy       = (state != S_IDLE);
  assign load_ready = (state == S_LOAD);
  assign loaden     = load_valid & load_ready;
  assign rd_en      = (state == S_READ);
  assign rd_address = rd_addr_q;
  assign rd_layer   = rd_en & layer_q[0];
  assign unload_en  = (state == S_UNLOAD);
  assign unloadAddress = ul_addr_q;
  assign done       = (state == S_FIN);
  assign itr_count  = itr_q;
  assign hd_valid   = hd_vld_p0;

  assign wr_en    = vld_pipe[PIPESTAGES-1];
  assign wr_layer = wr_en & layer_pipe[PIPESTAGES-1];
  // The final write of a layer is the one with no further write queued behind it.
  assign last_wr  = wr_en & ~vld_pipe[PIPESTAGES-2];
  assign firstprocessing_indicate = (rd_en & itr_zero) | (wr_en & first_pipe[PIPESTAGES-1]);

  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat_q;
    layer_nxt   = layer_q;
    itr_nxt     = itr_q;
    rd_addr_nxt = rd_addr_q;
    ul_addr_nxt = ul_addr_q;
    case (state)
      S_IDLE: begin
        beat_nxt  = '0;
        layer_nxt = '0;
        if (start) begin
          itr_nxt   = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          if (beat_q == BEATW'(LOADBEATS - 1)) begin
            beat_nxt  = '0;
            layer_nxt = '0;
            state_nxt = S_READ;
          end else begin
            beat_nxt = beat_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (rd_addr_q == ROWWIDTH'(ROWDEPTH - 1)) begin
          rd_addr_nxt = '0;
          state_nxt   = S_DRAIN;
        end else begin
          rd_addr_nxt = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (last_wr) begin
          if (!layer_last) begin
            layer_nxt = layer_q + 1'b1;
            state_nxt = S_READ;
          end else begin
            layer_nxt = '0;
            itr_nxt   = itr_inc;
            if (itr_inc >= ITRWIDTH'(MAXITRS))
              state_nxt = S_UNLOAD;
`ifdef LMEM_EARLY_TERM_EN
            else if (parity_ok)
              state_nxt = S_UNLOAD;
`endif
            else
              state_nxt = S_READ;
          end
        end
      end
      S_UNLOAD: begin
        if (ul_addr_q == ROWWIDTH'(UNLOADBEATS - 1)) begin
          ul_addr_nxt = '0;
          state_nxt   = S_FIN;
        end else begin
          ul_addr_nxt = ul_addr_q + 1'b1;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_q    <= '0;
      layer_q   <= '0;
      itr_q     <= '0;
      rd_addr_q <= '0;
      ul_addr_q <= '0;
      vld_pipe  <= '0;
      hd_vld_p0 <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_q    <= beat_nxt;
      layer_q   <= layer_nxt;
      itr_q     <= itr_nxt;
      rd_addr_q <= rd_addr_nxt;
      ul_addr_q <= ul_addr_nxt;
      vld_pipe  <= {vld_pipe[PIPESTAGES-2:0], rd_en};
      hd_vld_p0 <= unload_en;
    end
  end

  // Read-to-write pipe: layer and first-iteration tag ride alongside the valid bit.
  always_ff @(posedge clk) begin
    layer_pipe <= {layer_pipe[PIPESTAGES-2:0], rd_layer};
    first_pipe <= {first_pipe[PIPESTAGES-2:0], itr_zero};
  end

endmodule
